// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-style floating-point add/subtract (one shift per cycle in ALIGN/NORM).
// Define FP_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] result_o,
  output logic         overflow_o,
  output logic         underflow_o,
  output logic         invalid_o,
  output logic         zero_o
);
  localparam int SW = MAN_W + 4;  // hidden, fraction, guard, round, sticky
  localparam logic [EXP_W:0]   EMAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W-1:0] DMAX = EXP_W'(MAN_W + 3);
  localparam logic [W-1:0]     QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND, S_DONE} state_e;
  state_e state_q, state_d;

  logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic             op_q, op_d, sign_q, sign_d, sub_q, sub_d;
  logic [SW-1:0]    asig_q, asig_d, bsig_q, bsig_d;
  logic [SW:0]      sum_q, sum_d;
  logic [EXP_W:0]   exp_q, exp_d;
  logic [EXP_W-1:0] diff_q, diff_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d, zero_q, zero_d;

  logic [EXP_W-1:0] ea, eb, dexp;
  logic [MAN_W-1:0] fa, fb;
  logic             sa, sb, swap;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [SW:0]      addsub;
  logic [EXP_W:0]   rexp;
  logic [MAN_W-1:0] rfrac;

  assign ea     = a_q[W-2:MAN_W];
  assign eb     = b_q[W-2:MAN_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign sa     = a_q[W-1];
  assign sb     = b_q[W-1] ^ op_q;  // effective sign of b
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign swap   = b_q[W-2:0] > a_q[W-2:0];
  assign dexp   = swap ? (eb - ea) : (ea - eb);
  assign addsub = sub_q ? ({1'b0, asig_q} - {1'b0, bsig_q}) : ({1'b0, asig_q} + {1'b0, bsig_q});

`ifdef FP_ROUND_NEAREST_EN
  logic [MAN_W:0]   mant;
  logic             rinc;
  logic [MAN_W+1:0] rsum;
  assign mant  = sum_q[SW-1:3];
  assign rinc  = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
  assign rsum  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rinc};
  assign rexp  = exp_q + {{EXP_W{1'b0}}, rsum[MAN_W+1]};
  assign rfrac = rsum[MAN_W+1] ? rsum[MAN_W:1] : rsum[MAN_W-1:0];
`else
  assign rexp  = exp_q;
  assign rfrac = sum_q[SW-2:3];
`endif

  always_comb begin
    state_d = state_q;
    a_d = a_q; b_d = b_q; op_d = op_q; res_d = res_q;
    sign_d = sign_q; sub_d = sub_q; asig_d = asig_q; bsig_d = bsig_q;
    sum_d = sum_q; exp_d = exp_q; diff_d = diff_q;
    ovf_d = ovf_q; unf_d = unf_q; inv_d = inv_q; zero_d = zero_q;
    case (state_q)
      S_IDLE: if (in_valid_i) begin
        a_d = a_i; b_d = b_i; op_d = op_i;
        ovf_d = 1'b0; unf_d = 1'b0; inv_d = 1'b0; zero_d = 1'b0;
        state_d = S_UNPACK;
      end
      S_UNPACK: begin
        state_d = S_DONE;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
          res_d = QNAN;
          inv_d = 1'b1;
        end else if (a_inf) res_d = a_q;
        else if (b_inf)     res_d = {sb, b_q[W-2:0]};
        else if (b_zero)    res_d = a_zero ? {sa, {(W-1){1'b0}}} : a_q;
        else if (a_zero)    res_d = {sb, b_q[W-2:0]};
        else begin
          sign_d = swap ? sb : sa;
          sub_d  = sa ^ sb;
          exp_d  = {1'b0, swap ? eb : ea};
          asig_d = swap ? {1'b1, fb, 3'b000} : {1'b1, fa, 3'b000};
          bsig_d = swap ? {1'b1, fa, 3'b000} : {1'b1, fb, 3'b000};
          diff_d = dexp;
          if (dexp > DMAX) begin
            bsig_d  = SW'(1);  // B lies entirely below the sticky position
            state_d = S_ADDSUB;
          end else if (dexp == '0) state_d = S_ADDSUB;
          else                     state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        bsig_d = {1'b0, bsig_q[SW-1:2], bsig_q[1] | bsig_q[0]};
        diff_d = diff_q - EXP_W'(1);
        if (diff_q == EXP_W'(1)) state_d = S_ADDSUB;
      end
      S_ADDSUB: begin
        if (addsub == '0) begin
          res_d   = '0;
          state_d = S_DONE;
        end else begin
          sum_d   = addsub;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (sum_q[SW]) begin
          sum_d   = {1'b0, sum_q[SW:2], sum_q[1] | sum_q[0]};
          exp_d   = exp_q + (EXP_W+1)'(1);
          state_d = S_ROUND;
        end else if (sum_q[SW-1]) state_d = S_ROUND;
        else if (exp_q <= (EXP_W+1)'(1)) begin
          res_d   = {sign_q, {(W-1){1'b0}}};
          unf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          sum_d = {sum_q[SW-1:0], 1'b0};
          exp_d = exp_q - (EXP_W+1)'(1);
        end
      end
      S_ROUND: begin
        if (rexp >= EMAX) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
        end else res_d = {sign_q, rexp[EXP_W-1:0], rfrac};
        state_d = S_DONE;
      end
      S_DONE: if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // zero flag follows whatever result is delivered
    if (state_d == S_DONE && state_q != S_DONE) zero_d = (res_d[W-2:0] == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q <= '0; b_q <= '0; op_q <= 1'b0; res_q <= '0;
      sign_q <= 1'b0; sub_q <= 1'b0; asig_q <= '0; bsig_q <= '0;
      sum_q <= '0; exp_q <= '0; diff_q <= '0;
      ovf_q <= 1'b0; unf_q <= 1'b0; inv_q <= 1'b0; zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d; b_q <= b_d; op_q <= op_d; res_q <= res_d;
      sign_q <= sign_d; sub_q <= sub_d; asig_q <= asig_d; bsig_q <= bsig_d;
      sum_q <= sum_d; exp_q <= exp_d; diff_q <= diff_d;
      ovf_q <= ovf_d; unf_q <= unf_d; inv_q <= inv_d; zero_q <= zero_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign result_o    = res_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign invalid_o   = inv_q;
  assign zero_o      = zero_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed vector table plus hand-written handshake/reset sequences for fp_addsub_seq.
// Latency is counted in rising edges after the accept edge.
module tb_fp_addsub_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic        overflow, underflow, invalid, zero;

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .overflow_o(overflow), .underflow_o(underflow),
    .invalid_o(invalid), .zero_o(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a, b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  flg;  // {overflow, underflow, invalid, zero}
    int          lat;  // -1: not checked
  } vec_t;

`ifdef FP_ROUND_NEAREST_EN
  localparam logic [31:0] RND_UP_RES = 32'h3F800001;
`else
  localparam logic [31:0] RND_UP_RES = 32'h3F800000;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_op(input logic [31:0] va, input logic [31:0] vb, input logic vop, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("in_ready_before_op", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    a = va; b = vb; op = vop; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk("out_valid_timeout", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    vq.push_back('{"one_plus_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 4});
    vq.push_back('{"one_minus_one",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0001, -1});
    vq.push_back('{"inf_minus_inf",  32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0010, 1});
    vq.push_back('{"max_plus_max",   32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1000, 4});
    vq.push_back('{"min_norm_cancel",32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0101, -1});
    vq.push_back('{"round_up_sticky",32'h3F800000, 32'h33800001, 1'b0, RND_UP_RES,   4'b0000, 28});
    vq.push_back('{"round_tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000, 28});
    vq.push_back('{"two_plus_one",   32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000, 5});
    vq.push_back('{"three_minus_one",32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 5});
    vq.push_back('{"one_minus_two",  32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 6});
    vq.push_back('{"zero_plus_one",  32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 1});
    vq.push_back('{"one_minus_zero", 32'h3F800000, 32'h00000000, 1'b1, 32'h3F800000, 4'b0000, 1});
    vq.push_back('{"nan_plus_one",   32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0010, 1});
    vq.push_back('{"neg_inf_plus",   32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, 1});
    vq.push_back('{"one_sub_negone", 32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 4'b0000, 4});
    vq.push_back('{"one_plus_ulp",   32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 4'b0000, 27});
    vq.push_back('{"ulp_cancel_norm",32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000, 27});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready",  {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_result",    result, 32'd0);
    chk("reset_flags",     {28'b0, overflow, underflow, invalid, zero}, 32'd0);
    @(negedge clk) rst = 1'b0;

    foreach (vq[i]) begin
      do_op(vq[i].a, vq[i].b, vq[i].op, lat);
      chk({vq[i].name, "_result"}, result, vq[i].res);
      chk({vq[i].name, "_flags"}, {28'b0, overflow, underflow, invalid, zero}, {28'b0, vq[i].flg});
      if (vq[i].lat >= 0) chk({vq[i].name, "_latency"}, lat, vq[i].lat);
      release_out();
    end

    // Back-pressure: DONE holds its outputs until out_ready
    do_op(32'h3F800000, 32'h3F800000, 1'b0, lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_result",    result, 32'h40000000);
      chk("hold_flags",     {28'b0, overflow, underflow, invalid, zero}, 32'd0);
      chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_in_ready",  {31'b0, in_ready}, 32'd0);
    end
    release_out();
    chk("after_release_in_ready",  {31'b0, in_ready}, 32'd1);
    chk("after_release_out_valid", {31'b0, out_valid}, 32'd0);
    do_op(32'h40000000, 32'h3F800000, 1'b0, lat);
    chk("after_hold_result", result, 32'h40400000);
    release_out();

    // Reset in the middle of ALIGN
    @(negedge clk);
    a = 32'h4B000000; b = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("align_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("align_rst_in_ready",  {31'b0, in_ready}, 32'd1);
    chk("align_rst_result",    result, 32'd0);
    @(negedge clk) rst = 1'b0;
    do_op(32'h4B000000, 32'h3F800000, 1'b0, lat);
    chk("post_rst_result", result, 32'h4B000001);
    chk("post_rst_latency", lat, 27);
    release_out();

    // Reset while DONE is held, with in_valid on the same edge
    do_op(32'h3F800000, 32'h3F800000, 1'b0, lat);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 32'h7F800000; b = 32'h7F800000; op = 1'b1;
    @(posedge clk); #1;
    chk("done_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("done_rst_in_ready",  {31'b0, in_ready}, 32'd1);
    chk("done_rst_flags",     {28'b0, overflow, underflow, invalid, zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prio_in_ready",  {31'b0, in_ready}, 32'd1);
    chk("rst_prio_out_valid", {31'b0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
